// File: rtl/simplez_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the Simplez CPU bus.
// All state moves on the falling edge of clk, in step with the CPU.
module simplez_uart_tx #(
    parameter int         BAUD_DIV  = 104,
    parameter logic [8:0] ADDR_DATA = 9'o101,
    parameter logic [8:0] ADDR_STAT = 9'o102
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [8:0]  addr,
    input  logic        wr,
    input  logic [11:0] data_in,
    output logic [11:0] data_out,
    output logic        cs,
    output logic        tx,
    output logic        busy
);

    localparam int CW = $clog2(BAUD_DIV);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          ovr_q, ovr_d;

    logic wr_data, wr_stat, baud_tc;
    logic unused_hi;

    assign wr_data   = wr && (addr == ADDR_DATA);
    assign wr_stat   = wr && (addr == ADDR_STAT);
    assign baud_tc   = (baud_q == CW'(BAUD_DIV - 1));
    assign unused_hi = ^data_in[11:8];

    always_ff @(negedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        ovr_d   = ovr_q;

        // Clear first so a coincident overrun set would win.
        if (wr_stat) ovr_d = 1'b0;
        if (wr_data && state_q != IDLE) ovr_d = 1'b1;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (wr_data) begin
                    shift_d = data_in[7:0];
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_tc) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            DATA: begin
                if (baud_tc) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            STOP: begin
                if (baud_tc) begin
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign cs       = (addr == ADDR_DATA) || (addr == ADDR_STAT);
    assign data_out = (addr == ADDR_STAT) ? {10'b0, ovr_q, busy_q} : 12'h000;

endmodule
